// File: rtl/sram_stage_sequencer_pkg.sv
// Shared definitions for the SRAM stage sequencer: FSM encoding and SRAM port widths.
package sram_stage_sequencer_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ENABLE    = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_FINISH    = 3'd4
    } state_e;

    // Index width that stays legal for single-entry ranges.
    function automatic int safe_clog2(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/sram_port_mux.sv
// Registered N-to-1 selector placing the granted stage's write port onto the shared SRAM port.
module sram_port_mux
    import sram_stage_sequencer_pkg::*;
#(
    parameter int NUM_STAGES = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_STAGES-1:0]        sel,
    input  logic [NUM_STAGES-1:0]        stage_wren,
    input  logic [ADDR_W*NUM_STAGES-1:0] stage_address,
    input  logic [DATA_W*NUM_STAGES-1:0] stage_data_write,
    output logic                         wren,
    output logic [ADDR_W-1:0]            address,
    output logic [DATA_W-1:0]            data_write
);

    logic [ADDR_W-1:0] addr_arr [NUM_STAGES];
    logic [DATA_W-1:0] data_arr [NUM_STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_unpack
            assign addr_arr[gi] = stage_address[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = stage_data_write[gi*DATA_W +: DATA_W];
        end
    endgenerate

    logic              wren_d, wren_q;
    logic [ADDR_W-1:0] address_d, address_q;
    logic [DATA_W-1:0] data_write_d, data_write_q;

    // AND-OR select: an all-zero select yields an idle (non-writing) port.
    always_comb begin
        wren_d       = 1'b0;
        address_d    = '0;
        data_write_d = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (sel[i]) begin
                wren_d       = wren_d | stage_wren[i];
                address_d    = address_d | addr_arr[i];
                data_write_d = data_write_d | data_arr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wren_q       <= 1'b0;
            address_q    <= '0;
            data_write_q <= '0;
        end else begin
            wren_q       <= wren_d;
            address_q    <= address_d;
            data_write_q <= data_write_d;
        end
    end

    assign wren       = wren_q;
    assign address    = address_q;
    assign data_write = data_write_q;

endmodule

// File: rtl/sram_stage_sequencer.sv
// Grants the shared frame SRAM port to the masked stages one at a time, in ascending order,
// aborting a stage that holds the port too long.
module sram_stage_sequencer
    import sram_stage_sequencer_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int TIMEOUT_CYCLES = 1048576,
    localparam int CS_W          = safe_clog2(NUM_STAGES)
) (
    input  logic                         clk_div_by_two,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [NUM_STAGES-1:0]        stage_mask,
    output logic [NUM_STAGES-1:0]        stage_enable,
    input  logic [NUM_STAGES-1:0]        stage_done,
    input  logic [NUM_STAGES-1:0]        stage_wren,
    input  logic [ADDR_W*NUM_STAGES-1:0] stage_address,
    input  logic [DATA_W*NUM_STAGES-1:0] stage_data_write,
    output logic                         wren,
    output logic [ADDR_W-1:0]            address,
    output logic [DATA_W-1:0]            data_write,
    output logic                         busy,
    output logic                         sequence_done,
    output logic                         timeout_error,
    output logic [CS_W-1:0]              current_stage
);

    localparam int TM_W = safe_clog2(TIMEOUT_CYCLES);
    localparam logic [TM_W-1:0] TM_LIMIT = TM_W'(TIMEOUT_CYCLES - 1);

    state_e                  state_d, state_q;
    logic [NUM_STAGES-1:0]   pending_d, pending_q;
    logic [NUM_STAGES-1:0]   stage_enable_d, stage_enable_q;
    logic [CS_W-1:0]         current_stage_d, current_stage_q;
    logic [TM_W-1:0]         timer_d, timer_q;
    logic                    busy_d, busy_q;
    logic                    sequence_done_d, sequence_done_q;
    logic                    timeout_error_d, timeout_error_q;

    logic [CS_W-1:0]         lowest_idx;
    logic [NUM_STAGES-1:0]   lowest_onehot;
    logic                    done_cur;

    // Scan downward so the lowest set pending bit is the one left standing.
    always_comb begin
        lowest_idx    = '0;
        lowest_onehot = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lowest_idx    = CS_W'(i);
                lowest_onehot = '0;
                lowest_onehot[i] = 1'b1;
            end
        end
    end

    assign done_cur = stage_done[current_stage_q];

    always_comb begin
        state_d         = state_q;
        pending_d       = pending_q;
        stage_enable_d  = stage_enable_q;
        current_stage_d = current_stage_q;
        timer_d         = timer_q;
        busy_d          = busy_q;
        sequence_done_d = 1'b0;
        timeout_error_d = timeout_error_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pending_d       = stage_mask;
                    timeout_error_d = 1'b0;
                    busy_d          = 1'b1;
                    state_d         = (|stage_mask) ? ST_ENABLE : ST_FINISH;
                end
            end
            ST_ENABLE: begin
                stage_enable_d  = lowest_onehot;
                current_stage_d = lowest_idx;
                timer_d         = '0;
                state_d         = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // A done arriving on the last permitted cycle still counts as success.
                if (done_cur) begin
                    pending_d      = pending_q & ~stage_enable_q;
                    stage_enable_d = '0;
                    state_d        = ST_RELEASE;
                end else if (timer_q == TM_LIMIT) begin
                    timeout_error_d = 1'b1;
                    pending_d       = '0;
                    stage_enable_d  = '0;
                    state_d         = ST_RELEASE;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!done_cur) begin
                    state_d = (|pending_q) ? ST_ENABLE : ST_FINISH;
                end
            end
            ST_FINISH: begin
                sequence_done_d = 1'b1;
                busy_d          = 1'b0;
                current_stage_d = '0;
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_div_by_two) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            pending_q       <= '0;
            stage_enable_q  <= '0;
            current_stage_q <= '0;
            timer_q         <= '0;
            busy_q          <= 1'b0;
            sequence_done_q <= 1'b0;
            timeout_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            stage_enable_q  <= stage_enable_d;
            current_stage_q <= current_stage_d;
            timer_q         <= timer_d;
            busy_q          <= busy_d;
            sequence_done_q <= sequence_done_d;
            timeout_error_q <= timeout_error_d;
        end
    end

    // Selecting on the next-cycle enable keeps the mux output aligned with stage_enable.
    sram_port_mux #(
        .NUM_STAGES (NUM_STAGES)
    ) u_port_mux (
        .clk              (clk_div_by_two),
        .reset_n          (reset_n),
        .sel              (stage_enable_d),
        .stage_wren       (stage_wren),
        .stage_address    (stage_address),
        .stage_data_write (stage_data_write),
        .wren             (wren),
        .address          (address),
        .data_write       (data_write)
    );

    assign stage_enable  = stage_enable_q;
    assign busy          = busy_q;
    assign sequence_done = sequence_done_q;
    assign timeout_error = timeout_error_q;
    assign current_stage = current_stage_q;

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Bench for sram_stage_sequencer: a per-cycle schedule model built from each accepted start,
// checked every cycle, plus hand-computed literal checks for the directed scenarios.
module tb_sram_stage_sequencer;

    localparam int N    = 4;
    localparam int TO   = 16;
    localparam int MAXC = 512;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [3:0]    stage_mask;
    logic [3:0]    stage_enable;
    logic [3:0]    stage_done;
    logic [3:0]    stage_wren;
    logic [71:0]   stage_address;
    logic [127:0]  stage_data_write;
    logic          wren;
    logic [17:0]   address;
    logic [31:0]   data_write;
    logic          busy;
    logic          sequence_done;
    logic          timeout_error;
    logic [1:0]    current_stage;

    sram_stage_sequencer #(
        .NUM_STAGES     (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_div_by_two   (clk),
        .reset_n          (reset_n),
        .start            (start),
        .stage_mask       (stage_mask),
        .stage_enable     (stage_enable),
        .stage_done       (stage_done),
        .stage_wren       (stage_wren),
        .stage_address    (stage_address),
        .stage_data_write (stage_data_write),
        .wren             (wren),
        .address          (address),
        .data_write       (data_write),
        .busy             (busy),
        .sequence_done    (sequence_done),
        .timeout_error    (timeout_error),
        .current_stage    (current_stage)
    );

    always #5 clk = ~clk;

    // Expected schedule, indexed by cycle number (cycle c = interval after rising edge c).
    logic [3:0]  exp_en   [MAXC];
    bit          exp_busy [MAXC];
    bit          exp_sd   [MAXC];
    bit          exp_terr [MAXC];
    logic [3:0]  hist_wren [MAXC];
    logic [17:0] hist_addr [MAXC][N];
    logic [31:0] hist_data [MAXC][N];

    int done_lat [N];
    int cnt [N];
    int cyc;
    int n_cmp;
    int n_err;
    int sd_count;
    int sd_cycle;
    int en0_cnt;
    int pin_cycle;
    int pin_hits;
    logic [3:0] seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end else begin
            $display("ok   %s at cycle %0d: 0x%0h", name, cyc, act);
        end
    endtask

    // Stage run times follow from the rules: one ENABLE cycle, L cycles granted, one release
    // cycle (stage models drop done with their enable), then the next grant or FINISH.
    task automatic plan(input int s, input logic [3:0] m);
        int c;
        int len;
        int fin;
        bit to;
        for (int k = s; k < MAXC; k++) begin
            exp_en[k] = 4'b0; exp_busy[k] = 1'b0; exp_sd[k] = 1'b0; exp_terr[k] = 1'b0;
        end
        fin = s;
        c   = s + 1;
        to  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m[i] && !to) begin
                to  = (done_lat[i] == 0) || (done_lat[i] > TO);
                len = to ? TO : done_lat[i];
                for (int k = c; k < c + len; k++) exp_en[k] = 4'(1 << i);
                fin = c + len + 1;
                if (to) for (int k = c + len; k < MAXC; k++) exp_terr[k] = 1'b1;
                c = c + len + 2;
            end
        end
        for (int k = s; k <= fin; k++) exp_busy[k] = 1'b1;
        exp_sd[fin + 1] = 1'b1;
    endtask

    task automatic compare();
        logic [3:0]  e;
        logic        ew;
        logic [17:0] ea;
        logic [31:0] ed;
        int          ci;
        e  = exp_en[cyc];
        ew = 1'b0; ea = '0; ed = '0; ci = 0;
        for (int i = 0; i < N; i++) begin
            if (e[i]) begin
                ew = hist_wren[cyc-1][i];
                ea = hist_addr[cyc-1][i];
                ed = hist_data[cyc-1][i];
                ci = i;
            end
        end
        chk("stage_enable", stage_enable, e);
        chk("busy", busy, exp_busy[cyc]);
        chk("sequence_done", sequence_done, exp_sd[cyc]);
        chk("timeout_error", timeout_error, exp_terr[cyc]);
        chk("wren", wren, ew);
        chk("address", address, ea);
        chk("data_write", data_write, ed);
        if (e != 4'b0) chk("current_stage", current_stage, ci);
        else if (!exp_busy[cyc]) chk("current_stage_idle", current_stage, 0);
        if (cyc == pin_cycle + 1) begin
            pin_hits++;
            chk("pin_wren", wren, 1);
            chk("pin_address", address, 79041);
        end
        if (sequence_done) begin sd_count++; sd_cycle = cyc; end
        seen = seen | stage_enable;
        if (stage_enable[0]) en0_cnt++;
    endtask

    // One clock: stage models and data drivers just after the edge, checks at the falling edge.
    task automatic tick();
        int a;
        int d;
        bit w;
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < N; i++) begin
            if (stage_enable[i]) cnt[i]++; else cnt[i] = 0;
            stage_done[i] = stage_enable[i] && (done_lat[i] != 0) && (cnt[i] >= done_lat[i]);
            a = (cyc * 37 + i * 4099) % 262144;
            d = cyc * 65536 + i * 17 + 5;
            w = (i == 1) ? 1'b1 : ((cyc + i) % 3 != 0);
            if (i == 0 && stage_enable[0] && cnt[0] == 3 && done_lat[0] > 4) begin
                a = 79041; w = 1'b1; pin_cycle = cyc;
            end
            stage_address[i*18 +: 18]    = 18'(a);
            stage_data_write[i*32 +: 32] = 32'(d);
            stage_wren[i]                = w;
            hist_addr[cyc][i]            = 18'(a);
            hist_data[cyc][i]            = 32'(d);
        end
        hist_wren[cyc] = stage_wren;
        @(negedge clk);
        compare();
    endtask

    task automatic do_start(input logic [3:0] m, output int s);
        start      = 1'b1;
        stage_mask = m;
        s          = cyc + 1;
        if (!exp_busy[cyc] && reset_n) plan(s, m);
        tick();
        start      = 1'b0;
        stage_mask = 4'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int k = cyc + 1; k < MAXC; k++) begin
            exp_en[k] = 4'b0; exp_busy[k] = 1'b0; exp_sd[k] = 1'b0; exp_terr[k] = 1'b0;
        end
        tick();
        reset_n = 1'b1;
    endtask

    task automatic clear_mon();
        sd_count = 0; sd_cycle = -1; en0_cnt = 0; seen = 4'b0; pin_hits = 0;
    endtask

    initial begin
        int s;
        int s_ign;
        for (int k = 0; k < MAXC; k++) begin
            exp_en[k] = 4'b0; exp_busy[k] = 1'b0; exp_sd[k] = 1'b0; exp_terr[k] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin done_lat[i] = 10; cnt[i] = 0; end
        cyc = 0; n_cmp = 0; n_err = 0; pin_cycle = -10;
        clear_mon();
        reset_n = 1'b0; start = 1'b0; stage_mask = 4'b0;
        stage_done = 4'b0; stage_wren = 4'b0; stage_address = '0; stage_data_write = '0;

        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_enable", stage_enable, 0);
        chk("rst_timeout_error", timeout_error, 0);
        chk("rst_wren", wren, 0);
        chk("rst_current_stage", current_stage, 0);

        // Mask 0101, done after 10 enabled cycles; a second start while busy must be ignored.
        clear_mon();
        do_start(4'b0101, s);
        repeat (4) tick();
        do_start(4'b1000, s_ign);
        repeat (30) tick();
        chk("t1_seen", seen, 4'b0101);
        chk("t1_sd_count", sd_count, 1);
        chk("t1_sd_cycle", sd_cycle, s + 25);
        chk("t1_pin_hits", pin_hits, 1);

        // Stage 0 never done: aborted after 16 cycles, stage 1 skipped.
        done_lat[0] = 0;
        clear_mon();
        do_start(4'b0011, s);
        repeat (25) tick();
        chk("t2_en0_cycles", en0_cnt, 16);
        chk("t2_timeout_error", timeout_error, 1);
        chk("t2_seen", seen, 4'b0001);
        chk("t2_sd_cycle", sd_cycle, s + 19);
        chk("t2_sd_count", sd_count, 1);

        // Empty mask: done two cycles after start, timeout flag cleared by the start.
        clear_mon();
        do_start(4'b0000, s);
        repeat (5) tick();
        chk("t3_sd_cycle", sd_cycle, s + 1);
        chk("t3_seen", seen, 4'b0000);
        chk("t3_timeout_error", timeout_error, 0);
        chk("t3_sd_count", sd_count, 1);

        // Reset while stage 1 holds the port.
        for (int i = 0; i < N; i++) done_lat[i] = 10;
        clear_mon();
        do_start(4'b0011, s);
        repeat (15) tick();
        chk("t4_pre_enable", stage_enable, 4'b0010);
        chk("t4_pre_current_stage", current_stage, 1);
        do_reset();
        chk("t4_enable", stage_enable, 0);
        chk("t4_busy", busy, 0);
        chk("t4_wren", wren, 0);
        chk("t4_address", address, 0);
        chk("t4_data_write", data_write, 0);
        chk("t4_current_stage", current_stage, 0);
        repeat (30) tick();
        chk("t4_sd_count", sd_count, 0);

        // All stages with short, uneven done latencies.
        done_lat[0] = 3; done_lat[1] = 1; done_lat[2] = 5; done_lat[3] = 2;
        clear_mon();
        do_start(4'b1111, s);
        repeat (25) tick();
        chk("t5_seen", seen, 4'b1111);
        chk("t5_sd_cycle", sd_cycle, s + 20);

        // Done on the last permitted cycle succeeds; one cycle later times out and drops stage 3.
        done_lat[1] = 16; done_lat[2] = 17; done_lat[3] = 5;
        clear_mon();
        do_start(4'b1110, s);
        repeat (42) tick();
        chk("t6_seen", seen, 4'b0110);
        chk("t6_timeout_error", timeout_error, 1);
        chk("t6_sd_cycle", sd_cycle, s + 37);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
